// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, control bundle and ID/EX record.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic uses_rt;
    logic zero_ext;
  } ctrl_t;

  // Fixed-width part of the E register; PC and operands live beside it at parameter width.
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
  } id_ex_t;

  function automatic logic is_legal_funct(input logic [5:0] f);
    return f inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
                     [FN_ADD:FN_NOR], FN_SLT, FN_SLTU};
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, [OP_ADDI:OP_LUI], OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational MIPS control decode of the instruction held in D.
// ID_ILLEGAL_TRAP_EN adds the illegal-instruction flag.
module id_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
`ifdef ID_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output ctrl_t       ctrl,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output logic [31:0] imm
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] dst_raw;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl    = '0;
    dst_raw = '0;
    case (opcode) inside
      OP_RTYPE: begin
        ctrl.uses_rt   = 1'b1;
        ctrl.reg_write = (funct != FN_JR);
        dst_raw        = instr[15:11];
      end
      OP_LW: begin
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        dst_raw        = rt;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: ctrl.uses_rt = 1'b1;
      [OP_ADDI:OP_LUI]: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
        dst_raw        = rt;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        dst_raw        = 5'd31;
      end
      default: ;  // j and unknown opcodes decode as NOP
    endcase
  end

  // A non-writing instruction reports no destination so hazard logic ignores it.
  assign dst = ctrl.reg_write ? dst_raw : 5'd0;
  assign imm = ctrl.zero_ext ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

`ifdef ID_ILLEGAL_TRAP_EN
  assign illegal = !is_known_op(opcode) | ((opcode == OP_RTYPE) & !is_legal_funct(funct));
`endif

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register D, control decode, ID/EX register E with load-use stall.
// ID_ILLEGAL_TRAP_EN adds the ex_illegal output.
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_ready,
  output logic [4:0]        rf_addr_1,
  output logic [4:0]        rf_addr_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  input  logic              flush,
  input  logic              ex_ready,
`ifdef ID_ILLEGAL_TRAP_EN
  output logic              ex_illegal,
`endif
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src
);

  logic            d_valid;
  logic [31:0]     d_instr;
  logic [PC_W-1:0] d_pc;
  id_ex_t          e_q;

  ctrl_t       dec_ctrl;
  logic [4:0]  dec_rs, dec_rt, dec_dst;
  logic [31:0] dec_imm;
  logic        e_free, hazard, advance;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        dec_illegal;
`endif

  id_decoder u_dec (
    .instr   (d_instr),
`ifdef ID_ILLEGAL_TRAP_EN
    .illegal (dec_illegal),
`endif
    .ctrl    (dec_ctrl),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .dst     (dec_dst),
    .imm     (dec_imm)
  );

  assign hazard = d_valid & ex_valid & e_q.mem_read & (e_q.dst != 5'd0) &
                  ((e_q.dst == dec_rs) | (dec_ctrl.uses_rt & (e_q.dst == dec_rt)));
  assign e_free   = !ex_valid | ex_ready;
  assign advance  = d_valid & e_free & !hazard;
  assign id_ready = !d_valid | advance;

  assign rf_addr_1 = d_valid ? dec_rs : 5'd0;
  assign rf_addr_2 = d_valid ? dec_rt : 5'd0;

  // NOTE: only d_valid is reset; the instruction/PC payload is qualified by it and needs no reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      d_valid <= 1'b0;
    end else if (if_valid && id_ready) begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      d_valid <= 1'b1;
      d_instr <= if_instr;
      d_pc    <= if_pc;
    end else if (advance) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_valid   <= 1'b0;
      e_q        <= '0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
    end else if (advance) begin
      ex_valid   <= 1'b1;
      e_q        <= '{imm: dec_imm, shamt: d_instr[10:6], opcode: d_instr[31:26],
                      funct: d_instr[5:0], dst: dec_dst, reg_write: dec_ctrl.reg_write,
                      mem_read: dec_ctrl.mem_read, mem_write: dec_ctrl.mem_write,
                      alu_src: dec_ctrl.alu_src};
      ex_pc      <= d_pc;
      ex_rs_data <= rf_data_1;
      ex_rt_data <= rf_data_2;
    end else if (e_free) begin
      // Stall or empty D: hand EX a bubble with all control cleared.
      ex_valid <= 1'b0;
      e_q      <= '0;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset || flush)  ex_illegal <= 1'b0;
    else if (advance)    ex_illegal <= dec_illegal;
    else if (e_free)     ex_illegal <= 1'b0;
  end
`endif

  assign ex_imm       = e_q.imm;
  assign ex_shamt     = e_q.shamt;
  assign ex_opcode    = e_q.opcode;
  assign ex_funct     = e_q.funct;
  assign ex_dst       = e_q.dst;
  assign ex_reg_write = e_q.reg_write;
  assign ex_mem_read  = e_q.mem_read;
  assign ex_mem_write = e_q.mem_write;
  assign ex_alu_src   = e_q.alu_src;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random traffic against a cycle model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc, rf_data_1, rf_data_2;
  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [4:0]  rf_addr_1, rf_addr_2, ex_shamt, ex_dst;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_opcode, ex_funct;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .flush(flush), .ex_ready(ex_ready),
`ifdef ID_ILLEGAL_TRAP_EN
    .ex_illegal(ex_illegal),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] cyc = 0;

  typedef struct { bit rw, mr, mw, as, ut, ill; logic [4:0] dst; logic [31:0] imm; } dec_t;
  typedef struct { bit v; logic [31:0] instr, pc; } md_t;
  typedef struct {
    bit v, rw, mr, mw, as, ill;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  shamt, dst;
    logic [5:0]  op, fn;
  } me_t;

  md_t md = '{default: 0};
  me_t me = '{default: 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written directly from the instruction-set rules.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d = '{default: 0};
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    bit zx = 0;
    case (op)
      6'h00: begin
        d.ut = 1; d.rw = (fn != 6'h08); d.dst = ins[15:11];
        d.ill = !(fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
                             [6'h20:6'h27], 6'h2A, 6'h2B});
      end
      6'h23: begin d.mr = 1; d.rw = 1; d.as = 1; d.dst = ins[20:16]; end
      6'h2B: begin d.mw = 1; d.ut = 1; d.as = 1; end
      6'h04, 6'h05: d.ut = 1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        d.rw = 1; d.as = 1; d.dst = ins[20:16];
        zx = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
      end
      6'h02: ;
      6'h03: begin d.rw = 1; d.dst = 5'd31; end
      default: d.ill = 1;
    endcase
    if (!d.rw) d.dst = 0;
    d.imm = zx ? {16'd0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] rf_val(input logic [4:0] a, input logic [31:0] c);
    return {a, 27'd0} ^ (c * 32'h9E37_79B9) ^ 32'h0000_1234;
  endfunction

  function automatic logic [4:0] rand_reg();
    logic [4:0] v = 5'($urandom_range(0, 3));
    return (v == 5'd3) ? 5'd8 : v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [15] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h05,
                             6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h3F};
    logic [5:0] op = ops[$urandom_range(0, 14)];
    return {op, rand_reg(), rand_reg(), rand_reg(), 5'($urandom), 6'($urandom)};
  endfunction

  task automatic compare_e();
    check("ex_valid", ex_valid, me.v);
    if (me.v) begin
      check("ex_pc", ex_pc, me.pc);
      check("ex_rs_data", ex_rs_data, me.a);
      check("ex_rt_data", ex_rt_data, me.b);
      check("ex_imm", ex_imm, me.imm);
      check("ex_shamt", ex_shamt, me.shamt);
      check("ex_opcode", ex_opcode, me.op);
      check("ex_funct", ex_funct, me.fn);
      check("ex_dst", ex_dst, me.dst);
    end
    check("ex_reg_write", ex_reg_write, me.v & me.rw);
    check("ex_mem_read", ex_mem_read, me.v & me.mr);
    check("ex_mem_write", ex_mem_write, me.v & me.mw);
    check("ex_alu_src", ex_alu_src, me.v & me.as);
`ifdef ID_ILLEGAL_TRAP_EN
    check("ex_illegal", ex_illegal, me.v & me.ill);
`endif
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check E after the edge.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit er = 1, input bit fl = 0, input bit rst = 0);
    dec_t d;
    md_t nd;
    me_t ne;
    logic [4:0] rs, rt;
    bit hz, efree, adv, rdy;
    rs = md.v ? md.instr[25:21] : 5'd0;
    rt = md.v ? md.instr[20:16] : 5'd0;
    reset = rst; if_valid = iv; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
    rf_data_1 = rf_val(rs, cyc);
    rf_data_2 = rf_val(rt, cyc);
    d     = decode(md.instr);
    hz    = md.v && me.v && me.mr && me.dst != 0 &&
            (me.dst == rs || (d.ut && me.dst == rt));
    efree = !me.v || er;
    adv   = md.v && efree && !hz;
    rdy   = !md.v || adv;
    #1;
    if (!rst) begin
      check("id_ready", id_ready, rdy);
      check("rf_addr_1", rf_addr_1, rs);
      check("rf_addr_2", rf_addr_2, rt);
    end
    nd = md;
    ne = me;
    if (rst || fl) begin
      nd = '{default: 0};
      ne = '{default: 0};
    end else begin
      if (iv && rdy) nd = '{v: 1, instr: ins, pc: pc};
      else if (adv)  nd.v = 0;
      if (adv)
        ne = '{v: 1, rw: d.rw, mr: d.mr, mw: d.mw, as: d.as, ill: d.ill,
               pc: md.pc, a: rf_data_1, b: rf_data_2, imm: d.imm,
               shamt: md.instr[10:6], dst: d.dst, op: md.instr[31:26], fn: md.instr[5:0]};
      else if (efree)
        ne = '{default: 0};
    end
    @(posedge clk);
    md = nd;
    me = ne;
    cyc++;
    @(negedge clk);
    compare_e();
  endtask

  initial begin
    reset = 1; if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 1; flush = 0;
    rf_data_1 = 0; rf_data_2 = 0;
    @(negedge clk);

    // Reset held two cycles.
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    reset = 0; #1;
    check("rst id_ready", id_ready, 1);
    check("rst rf_addr_1", rf_addr_1, 0);
    check("rst rf_addr_2", rf_addr_2, 0);
    check("rst ex_valid", ex_valid, 0);
    check("rst ex_pc", ex_pc, 0);
    check("rst ex_imm", ex_imm, 0);
    check("rst ex_dst", ex_dst, 0);
    check("rst ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src}, 0);

    // addi $9,$0,-5 reaches E two edges after acceptance.
    step(1, 32'h2009FFFB, 32'h100);
    step(0, 0, 0);
    check("addi valid", ex_valid, 1);
    check("addi dst", ex_dst, 9);
    check("addi imm", ex_imm, 32'hFFFF_FFFB);
    check("addi rw/as", {ex_reg_write, ex_alu_src}, 2'b11);
    check("addi pc", ex_pc, 32'h100);

    // lw $8 followed by a dependent add: one stall cycle and one bubble.
    step(1, 32'h8D280000, 32'h200);
    step(1, 32'h010B5020, 32'h204);
    check("lu stall id_ready", id_ready, 0);
    check("lu lw in E", ex_mem_read, 1);
    step(0, 0, 0);
    check("lu bubble", ex_valid, 0);
    check("lu release id_ready", id_ready, 1);
    step(0, 0, 0);
    check("lu add valid", ex_valid, 1);
    check("lu add dst", ex_dst, 10);
    check("lu add pc", ex_pc, 32'h204);

    // lw $0 never creates a hazard.
    step(1, 32'h8D200000, 32'h240);
    step(1, 32'h000B5020, 32'h244);
    check("lw0 id_ready", id_ready, 1);
    check("lw0 in E", ex_valid, 1);
    step(0, 0, 0);
    check("lw0 add b2b", ex_valid, 1);
    check("lw0 add pc", ex_pc, 32'h244);

    // ori zero-extends, then three cycles of back-pressure.
    step(1, 32'h34428000, 32'h300);
    step(0, 0, 0);
    check("ori imm", ex_imm, 32'h0000_8000);
    step(1, 32'h20030001, 32'h304, 0);
    check("bp pc 1", ex_pc, 32'h300);
    check("bp imm 1", ex_imm, 32'h0000_8000);
    step(1, 32'h20040002, 32'h308, 0);
    check("bp id_ready", id_ready, 0);
    check("bp pc 2", ex_pc, 32'h300);
    step(1, 32'h20040002, 32'h308, 0);
    check("bp pc 3", ex_pc, 32'h300);
    check("bp valid 3", ex_valid, 1);
    step(1, 32'h20040002, 32'h308, 1);
    check("bp resume pc", ex_pc, 32'h304);
    step(0, 0, 0);
    check("bp next pc", ex_pc, 32'h308);

    // Flush with live E and a simultaneous fetch transfer.
    step(1, 32'h20050005, 32'h400);
    step(1, 32'h20060006, 32'h404);
    check("fl E live", ex_valid, 1);
    step(1, 32'h20070007, 32'h408, 1, 1);
    check("fl ex_valid", ex_valid, 0);
    check("fl d empty", id_ready, 1);
    check("fl rf_addr_1", rf_addr_1, 0);
    step(0, 0, 0);
    check("fl discard 1", ex_valid, 0);
    step(0, 0, 0);
    check("fl discard 2", ex_valid, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, rand_instr(), 32'h1000 + (cyc << 2),
           ($urandom % 4) != 0, ($urandom % 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
